// File: rtl/pcie_rx_block_aligner.sv
// rtl/pcie_rx_block_aligner.sv - per-lane 128b/130b block aligner; PCIE_ALIGN_STATS_EN adds slip/loss counters
module pcie_rx_block_aligner #(
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4
) (
  input  logic         clk_phy,
  input  logic         rst_phy,
  input  logic [31:0]  pma_rx_data,
  input  logic         pma_rx_valid,
  input  logic         align_restart,
  output logic         blk_valid,
  output logic [1:0]   blk_hdr,
  output logic [127:0] blk_data,
  output logic         blk_hdr_err,
  output logic         block_lock,
  output logic         lock_loss,
  output logic [15:0]  slip_cnt,
  output logic [7:0]   loss_cnt
);

  typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t        state, state_next;
  logic [191:0]  bit_buf, buf_shift, buf_next;
  logic [7:0]    bit_cnt, cnt_after, cnt_next, consume;
  logic [3:0]    good_cnt, good_next, bad_cnt, bad_next;
  logic          eval, hdr_ok, loss, emit, hdr_err_d, lock_d;

  assign eval   = (bit_cnt >= 8'd130);
  assign hdr_ok = (bit_buf[1:0] == 2'b10) || (bit_buf[1:0] == 2'b01);

  always_ff @(posedge clk_phy) begin
    if (rst_phy) state <= ST_SEARCH;
    else         state <= state_next;
  end

  // A slip needs 131 buffered bits; with exactly 130 the FSM waits for the next word.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    bad_next   = bad_cnt;
    consume    = 8'd0;
    loss       = 1'b0;
    if (align_restart) begin
      state_next = ST_SEARCH;
      good_next  = 4'd0;
      bad_next   = 4'd0;
    end else if (eval) begin
      case (state)
        ST_SEARCH: begin
          if (hdr_ok) begin
            consume    = 8'd130;
            good_next  = 4'd1;
            state_next = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CHECK;
          end else if (bit_cnt >= 8'd131) begin
            consume = 8'd131;
          end
        end
        ST_CHECK: begin
          if (hdr_ok) begin
            consume   = 8'd130;
            good_next = good_cnt + 4'd1;
            if (good_next == LOCK_N) state_next = ST_LOCKED;
          end else if (bit_cnt >= 8'd131) begin
            consume    = 8'd131;
            good_next  = 4'd0;
            state_next = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          consume = 8'd130;
          if (hdr_ok) begin
            bad_next = 4'd0;
          end else begin
            bad_next = bad_cnt + 4'd1;
            if (bad_next == LOSS_N) begin
              loss       = 1'b1;
              state_next = ST_SEARCH;
              good_next  = 4'd0;
              bad_next   = 4'd0;
            end
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    hdr_err_d = 1'b0;
    lock_d    = 1'b0;
    if (!align_restart) begin
      emit      = eval && (state == ST_LOCKED);
      hdr_err_d = emit && !hdr_ok;
      lock_d    = (state_next == ST_LOCKED);
    end
  end

  // Bits above bit_cnt are kept zero so the new word can simply be OR-ed in.
  always_comb begin
    buf_shift = bit_buf >> consume;
    cnt_after = bit_cnt - consume;
    buf_next  = buf_shift;
    cnt_next  = cnt_after;
    if (pma_rx_valid) begin
      buf_next = buf_shift | ({160'b0, pma_rx_data} << cnt_after);
      cnt_next = cnt_after + 8'd32;
    end
    if (align_restart) begin
      buf_next = '0;
      cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clk_phy) begin
    if (rst_phy) begin
      bit_buf     <= '0;
      bit_cnt     <= 8'd0;
      good_cnt    <= 4'd0;
      bad_cnt     <= 4'd0;
      blk_valid   <= 1'b0;
      blk_hdr     <= 2'b00;
      blk_data    <= '0;
      blk_hdr_err <= 1'b0;
      block_lock  <= 1'b0;
      lock_loss   <= 1'b0;
    end else begin
      bit_buf     <= buf_next;
      bit_cnt     <= cnt_next;
      good_cnt    <= good_next;
      bad_cnt     <= bad_next;
      blk_valid   <= emit;
      blk_hdr_err <= hdr_err_d;
      block_lock  <= lock_d;
      lock_loss   <= loss;
      if (emit) begin
        blk_hdr  <= bit_buf[1:0];
        blk_data <= bit_buf[129:2];
      end
    end
  end

`ifdef PCIE_ALIGN_STATS_EN
  always_ff @(posedge clk_phy) begin
    if (rst_phy) begin
      slip_cnt <= 16'd0;
      loss_cnt <= 8'd0;
    end else begin
      if ((consume == 8'd131) && (slip_cnt != 16'hffff)) slip_cnt <= slip_cnt + 16'd1;
      if (loss && (loss_cnt != 8'hff)) loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  assign slip_cnt = 16'd0;
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pcie_rx_block_aligner.sv
// tb/tb_pcie_rx_block_aligner.sv - scoreboard bench for pcie_rx_block_aligner
module tb_pcie_rx_block_aligner;

  localparam int LOCK_COUNT = 8;
  localparam int LOSS_COUNT = 4;
`ifdef PCIE_ALIGN_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic         clk_phy = 1'b0;
  logic         rst_phy = 1'b1;
  logic [31:0]  pma_rx_data = 32'd0;
  logic         pma_rx_valid = 1'b0;
  logic         align_restart = 1'b0;
  logic         blk_valid;
  logic [1:0]   blk_hdr;
  logic [127:0] blk_data;
  logic         blk_hdr_err;
  logic         block_lock;
  logic         lock_loss;
  logic [15:0]  slip_cnt;
  logic [7:0]   loss_cnt;

  pcie_rx_block_aligner #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)) dut (
    .clk_phy(clk_phy), .rst_phy(rst_phy), .pma_rx_data(pma_rx_data),
    .pma_rx_valid(pma_rx_valid), .align_restart(align_restart),
    .blk_valid(blk_valid), .blk_hdr(blk_hdr), .blk_data(blk_data),
    .blk_hdr_err(blk_hdr_err), .block_lock(block_lock), .lock_loss(lock_loss),
    .slip_cnt(slip_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk_phy = ~clk_phy;

  typedef struct packed {
    logic [1:0]   hdr;
    logic [127:0] data;
    logic         err;
    logic         loss;
  } blk_t;

  blk_t exp_q[$];
  bit   stream[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_slips = 0;
  int   exp_losses = 0;
  logic model_locked = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int stat(input int v);
    return STATS_ON ? v : 0;
  endfunction

  task automatic push_block(input logic [1:0] hdr, input logic [127:0] data);
    stream.push_back(hdr[0]);
    stream.push_back(hdr[1]);
    for (int i = 0; i < 128; i++) stream.push_back(data[i]);
  endtask

  // Bit-level reference: walks candidate boundaries over the whole segment stream.
  task automatic run_model();
    int p = 0;
    int n = stream.size();
    int st = 0;
    int good = 0;
    int bad = 0;
    logic [1:0] h;
    logic ok;
    blk_t e;
    while (n - p >= 130) begin
      h  = {stream[p+1], stream[p]};
      ok = (h == 2'b10) || (h == 2'b01);
      if (st == 2) begin
        e.hdr = h;
        for (int i = 0; i < 128; i++) e.data[i] = stream[p+2+i];
        e.err  = !ok;
        e.loss = 1'b0;
        p += 130;
        if (ok) bad = 0; else bad++;
        if (bad == LOSS_COUNT) begin
          e.loss = 1'b1;
          st = 0; good = 0; bad = 0;
          exp_losses++;
        end
        exp_q.push_back(e);
      end else if (ok) begin
        p += 130;
        good = (st == 0) ? 1 : good + 1;
        st = (good >= LOCK_COUNT) ? 2 : 1;
      end else if (n - p >= 131) begin
        p += 131;
        good = 0;
        st = 0;
        exp_slips++;
      end else begin
        break;
      end
    end
    model_locked = (st == 2);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    @(posedge clk_phy);
    #1;
    pma_rx_valid  = v;
    pma_rx_data   = d;
    align_restart = r;
  endtask

  // mode 0: back-to-back words, 1: every other cycle, 2: every other cycle plus 4-cycle gaps
  task automatic run_segment(input int mode);
    logic [31:0] wd;
    int nw;
    while (stream.size() % 32 != 0) stream.push_back(1'b0);
    drive(1'b1, $urandom, 1'b1);
    drive(1'b0, $urandom, 1'b0);
    check("restart_block_lock", 128'(block_lock), 128'(0));
    check("restart_lock_loss", 128'(lock_loss), 128'(0));
    check("restart_loss_cnt", 128'(loss_cnt), 128'(stat(exp_losses)));
    run_model();
    nw = stream.size() / 32;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 32; j++) wd[j] = stream[32*w + j];
      drive(1'b1, wd, 1'b0);
      if (mode >= 1) drive(1'b0, $urandom, 1'b0);
      if (mode == 2 && (w % 5) == 4) repeat (4) drive(1'b0, $urandom, 1'b0);
    end
    repeat (12) drive(1'b0, $urandom, 1'b0);
    check("seg_blocks_pending", 128'(exp_q.size()), 128'(0));
    check("seg_block_lock", 128'(block_lock), 128'(model_locked));
    check("seg_slip_cnt", 128'(slip_cnt), 128'(stat(exp_slips)));
    check("seg_loss_cnt", 128'(loss_cnt), 128'(stat(exp_losses)));
    exp_q.delete();
    stream.delete();
  endtask

  always @(negedge clk_phy) begin
    blk_t e;
    if (rst_phy) begin
      prev_valid = 1'b0;
    end else begin
      if (blk_valid) begin
        check("blk_valid_spacing", 128'(prev_valid), 128'(0));
        check("blk_expected_pending", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("blk_hdr", 128'(blk_hdr), 128'(e.hdr));
          check("blk_data", blk_data, e.data);
          check("blk_hdr_err", 128'(blk_hdr_err), 128'(e.err));
          check("blk_lock_loss", 128'(lock_loss), 128'(e.loss));
          check("blk_block_lock", 128'(block_lock), 128'(!e.loss));
        end
      end else begin
        check("lock_loss_idle", 128'(lock_loss), 128'(0));
      end
      prev_valid = blk_valid;
    end
  end

  initial begin
    repeat (4) @(posedge clk_phy);
    #1;
    check("rst_blk_valid", 128'(blk_valid), 128'(0));
    check("rst_blk_hdr", 128'(blk_hdr), 128'(0));
    check("rst_blk_data", blk_data, 128'(0));
    check("rst_blk_hdr_err", 128'(blk_hdr_err), 128'(0));
    check("rst_block_lock", 128'(block_lock), 128'(0));
    check("rst_lock_loss", 128'(lock_loss), 128'(0));
    check("rst_slip_cnt", 128'(slip_cnt), 128'(0));
    check("rst_loss_cnt", 128'(loss_cnt), 128'(0));
    rst_phy = 1'b0;

    for (int k = 0; k < 20; k++) push_block(2'b10, {96'b0, 32'(k)});
    run_segment(0);

    repeat (37) stream.push_back(1'b1);
    for (int k = 0; k < 60; k++) push_block(2'b10, {96'b0, 32'(k)});
    run_segment(0);

    for (int k = 0; k < 30; k++) begin
      if ((k >= 10 && k < 13) || (k >= 14 && k < 18))
        push_block(2'b11, {$urandom, $urandom, $urandom, $urandom});
      else
        push_block(2'b10, {$urandom, $urandom, $urandom, $urandom});
    end
    run_segment(0);

    for (int k = 0; k < 24; k++)
      push_block(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, {$urandom, $urandom, $urandom, $urandom});
    run_segment(1);

    repeat (5) stream.push_back(1'b0);
    for (int k = 0; k < 30; k++) push_block(2'b10, {96'b0, 32'(k + 100)});
    run_segment(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
